// File: rtl/dcm_lock_seq.sv
// Power-up / lock sequencer for the clk31p5 DCM, clocked from the 27 MHz reference.
// Optional macro DCM_LOSS_CNT_EN adds an 8-bit saturating loss-of-lock counter port.
module dcm_lock_seq #(
    parameter int DCM_RST_CYCLES      = 3,
    parameter int LOCK_STABLE_CYCLES  = 64,
    parameter int LOCK_TIMEOUT_CYCLES = 4096,
    parameter int MAX_RETRIES         = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ready,
    output logic       dcm_rst,
    output logic       sys_rst,
    output logic       locked,
`ifdef DCM_LOSS_CNT_EN
    output logic [7:0] loss_count,
`endif
    output logic       fail
);

    localparam int CNT_MAX_A = (DCM_RST_CYCLES > LOCK_STABLE_CYCLES) ? DCM_RST_CYCLES : LOCK_STABLE_CYCLES;
    localparam int CNT_MAX   = (CNT_MAX_A > LOCK_TIMEOUT_CYCLES) ? CNT_MAX_A : LOCK_TIMEOUT_CYCLES;
    localparam int CNT_W     = $clog2(CNT_MAX + 1);
    localparam int RTY_W     = (MAX_RETRIES > 0) ? $clog2(MAX_RETRIES + 1) : 1;

    localparam logic [CNT_W-1:0] DCM_LAST = CNT_W'(DCM_RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRIES);

    typedef enum logic [2:0] {
        S_DCM_RST,
        S_WAIT_LOCK,
        S_STABLE,
        S_RUN,
        S_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [RTY_W-1:0] retry_q, retry_d;
    logic [1:0]       sync_q;
    logic             ready_s;
    logic             dcm_rst_q, sys_rst_q, locked_q, fail_q;

    assign ready_s = sync_q[1];

    // NOTE: every variable gets a default before the case so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        unique case (state_q)
            S_DCM_RST: begin
                if (cnt_q == DCM_LAST) state_d = S_WAIT_LOCK;
                else                   cnt_d   = cnt_q + 1'b1;
            end
            S_WAIT_LOCK: begin
                // A lock seen on the timeout edge takes priority over the retry.
                if (ready_s) begin
                    state_d = S_STABLE;
                end else if (cnt_q == TO_LAST) begin
                    if (retry_q == RTY_MAX) begin
                        state_d = S_FAIL;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        state_d = S_DCM_RST;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_STABLE: begin
                if (!ready_s)              state_d = S_WAIT_LOCK;
                else if (cnt_q == STB_LAST) state_d = S_RUN;
                else                        cnt_d   = cnt_q + 1'b1;
            end
            S_RUN: begin
                if (!ready_s) begin
                    state_d = S_DCM_RST;
                    retry_d = '0;
                end
            end
            S_FAIL:  ;
            default: state_d = S_DCM_RST;
        endcase
        // Each state starts its own count from zero.
        if (state_d != state_q) cnt_d = '0;
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_DCM_RST;
            cnt_q     <= '0;
            retry_q   <= '0;
            sync_q    <= 2'b00;
            dcm_rst_q <= 1'b1;
            sys_rst_q <= 1'b1;
            locked_q  <= 1'b0;
            fail_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            sync_q    <= {sync_q[0], ready};
            dcm_rst_q <= (state_d == S_DCM_RST);
            sys_rst_q <= (state_d != S_RUN);
            locked_q  <= (state_d == S_RUN);
            fail_q    <= (state_d == S_FAIL);
        end
    end

    assign dcm_rst = dcm_rst_q;
    assign sys_rst = sys_rst_q;
    assign locked  = locked_q;
    assign fail    = fail_q;

`ifdef DCM_LOSS_CNT_EN
    logic [7:0] loss_q, loss_d;

    always_comb begin
        loss_d = loss_q;
        if (state_q == S_RUN && state_d == S_DCM_RST && loss_q != 8'hFF)
            loss_d = loss_q + 8'd1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) loss_q <= 8'd0;
        else     loss_q <= loss_d;
    end

    assign loss_count = loss_q;
`endif

endmodule

// File: tb/tb_dcm_lock_seq.sv
// Scoreboard bench for dcm_lock_seq: a phase-level model turns each ready waveform into
// the expected list of output changes; a monitor pops and compares on every change.
module tb_dcm_lock_seq;

    localparam int P_DCM = 3;
    localparam int P_STB = 8;
    localparam int P_TO  = 32;
    localparam int P_RTY = 2;
    localparam int RMAX  = 2047;

    // Output vector {dcm_rst, sys_rst, locked, fail}
    localparam logic [3:0] V_RST  = 4'b1100;
    localparam logic [3:0] V_WAIT = 4'b0100;
    localparam logic [3:0] V_RUN  = 4'b0010;
    localparam logic [3:0] V_FAIL = 4'b0101;

    typedef struct {
        int         cyc;
        logic [3:0] v;
    } evt_t;

    typedef enum {PH_PULSE, PH_WAIT, PH_STABLE, PH_RUN} phase_e;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ready = 1'b0;
    logic dcm_rst, sys_rst, locked, fail;
`ifdef DCM_LOSS_CNT_EN
    logic [7:0] loss_count;
`endif

    evt_t       exp_q[$];
    bit         rdy[0:RMAX];
    int         tests = 0;
    int         fails = 0;
    int         cyc = 0;
    int         exp_losses = 0;
    logic [3:0] prev = V_RST;
    logic [3:0] model_last;
    bit         mon_en = 1'b0;

    dcm_lock_seq #(
        .DCM_RST_CYCLES     (P_DCM),
        .LOCK_STABLE_CYCLES (P_STB),
        .LOCK_TIMEOUT_CYCLES(P_TO),
        .MAX_RETRIES        (P_RTY)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .ready     (ready),
        .dcm_rst   (dcm_rst),
        .sys_rst   (sys_rst),
        .locked    (locked),
`ifdef DCM_LOSS_CNT_EN
        .loss_count(loss_count),
`endif
        .fail      (fail)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Synchronized ready as seen by the sequencer at edge k: two edges of delay.
    function automatic bit rs(input int k);
        if (k < 3 || k - 2 > RMAX) return 1'b0;
        return rdy[k-2];
    endfunction

    function automatic int first_level(input int a, input int b, input bit lvl);
        for (int k = a; k <= b; k++)
            if (rs(k) == lvl) return k;
        return 0;
    endfunction

    function automatic void emit(input int t, input logic [3:0] v, input int horizon);
        evt_t e;
        if (t <= horizon && v != model_last) begin
            e.cyc = t;
            e.v   = v;
            exp_q.push_back(e);
            model_last = v;
        end
    endfunction

    // Walks the lock procedure in whole phases, jumping time by the rule lengths.
    function automatic void build_expect(input int horizon);
        int     t = 0;
        int     k;
        int     retries = 0;
        bit     done = 1'b0;
        phase_e ph = PH_PULSE;
        model_last = V_RST;
        exp_losses = 0;
        while (!done && t <= horizon) begin
            case (ph)
                PH_PULSE: begin
                    emit(t, V_RST, horizon);
                    t  = t + P_DCM;
                    ph = PH_WAIT;
                end
                PH_WAIT: begin
                    emit(t, V_WAIT, horizon);
                    k = first_level(t + 1, t + P_TO, 1'b1);
                    if (k != 0) begin
                        t  = k;
                        ph = PH_STABLE;
                    end else begin
                        t = t + P_TO;
                        if (retries == P_RTY) begin
                            emit(t, V_FAIL, horizon);
                            done = 1'b1;
                        end else begin
                            retries++;
                            ph = PH_PULSE;
                        end
                    end
                end
                PH_STABLE: begin
                    k = first_level(t + 1, t + P_STB, 1'b0);
                    if (k != 0) begin
                        t  = k;
                        ph = PH_WAIT;
                    end else begin
                        t = t + P_STB;
                        emit(t, V_RUN, horizon);
                        ph = PH_RUN;
                    end
                end
                PH_RUN: begin
                    k = first_level(t + 1, horizon, 1'b0);
                    if (k == 0) begin
                        done = 1'b1;
                    end else begin
                        t       = k;
                        retries = 0;
                        if (exp_losses < 255) exp_losses++;
                        ph = PH_PULSE;
                    end
                end
                default: done = 1'b1;
            endcase
        end
    endfunction

    // Monitor: every change of the output vector consumes one expected event.
    initial begin
        logic [3:0] cur;
        evt_t       e;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                cyc++;
                cur = {dcm_rst, sys_rst, locked, fail};
                if (cur !== prev) begin
                    if (exp_q.size() == 0) begin
                        tests++;
                        fails++;
                        $display("FAIL unexpected_event: got %b at cycle %0d, expected no change", cur, cyc);
                    end else begin
                        e = exp_q.pop_front();
                        check("event_cycle", cyc, e.cyc);
                        check("event_outputs", {28'd0, cur}, {28'd0, e.v});
                    end
                    prev = cur;
                end
            end
        end
    end

    task automatic set_rdy(input int lo, input int hi, input bit val);
        for (int k = lo; k <= hi && k <= RMAX; k++) rdy[k] = val;
    endtask

    task automatic fill_random(input int horizon);
        int k = 1;
        int len;
        bit val = 1'($urandom_range(0, 1));
        set_rdy(0, RMAX, 1'b0);
        while (k <= horizon) begin
            len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 3) : $urandom_range(5, 40);
            set_rdy(k, k + len - 1, val);
            k   = k + len;
            val = ~val;
        end
    endtask

    // Asserts rst mid-cycle (whatever state the previous run left), then plays rdy[1..horizon].
    task automatic run_scn(input int horizon);
        @(posedge clk);
        #3;
        rst    = 1'b1;
        mon_en = 1'b0;
        #1;
        check("reset_values", {28'd0, dcm_rst, sys_rst, locked, fail}, {28'd0, V_RST});
`ifdef DCM_LOSS_CNT_EN
        check("reset_loss_count", {24'd0, loss_count}, 32'd0);
`endif
        ready = 1'b0;
        exp_q.delete();
        build_expect(horizon);
        repeat (2) @(negedge clk);
        #1;
        rst    = 1'b0;
        cyc    = 0;
        prev   = V_RST;
        mon_en = 1'b1;
        ready  = rdy[1];
        for (int k = 2; k <= horizon; k++) begin
            @(negedge clk);
            ready = rdy[k];
        end
        @(negedge clk);
        #2;
        mon_en = 1'b0;
        check("missing_events", exp_q.size(), 0);
`ifdef DCM_LOSS_CNT_EN
        check("loss_count", {24'd0, loss_count}, exp_losses);
`endif
    endtask

    initial begin
        // No lock ever: three pulses then FAIL at 105, then ready chatter is ignored.
        set_rdy(0, RMAX, 1'b0);
        for (int k = 110; k <= 220; k++) rdy[k] = 1'($urandom_range(0, 1));
        run_scn(220);

        // Lock sampled at edge 13, ten edges after the first dcm_rst fall; ends in RUN.
        set_rdy(0, RMAX, 1'b0);
        set_rdy(13, RMAX, 1'b1);
        run_scn(40);

        // Same lock, but stop while still in STABLE so the next rst lands mid-STABLE.
        run_scn(18);

        // One-cycle drop at the 5th STABLE cycle; release 10 edges after resampled high.
        set_rdy(0, RMAX, 1'b0);
        set_rdy(13, RMAX, 1'b1);
        rdy[18] = 1'b0;
        run_scn(50);

        // Loss in RUN, relock, then a second loss with no return: full retry budget again.
        set_rdy(0, RMAX, 1'b0);
        set_rdy(13, 60, 1'b1);
        set_rdy(71, 110, 1'b1);
        run_scn(300);

        // Random waveforms mixing sub-sync-depth glitches with long steady stretches.
        for (int n = 0; n < 6; n++) begin
            fill_random(400);
            run_scn(400);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dcm_lock_seq.md
Name: dcm_lock_seq

Overview:
- Power-up and lock sequencer on the consumer side of the clk31p5 DCM.
- Drives the DCM's active-high reset and watches its ready (locked) output.
- Releases a system reset to downstream logic only after lock has been stable for a programmed time.
- Re-pulses the DCM reset on lock timeout or loss of lock, and declares sticky failure after a bounded number of retries.
- Runs on the free-running 27 MHz reference clock, never on the DCM output.

Parameters:
- DCM_RST_CYCLES, 3: cycles dcm_rst is held high per reset pulse (DCM minimum is 3 CLKIN cycles).
- LOCK_STABLE_CYCLES, 64: consecutive synchronized-ready cycles required before system reset release.
- LOCK_TIMEOUT_CYCLES, 4096: cycles allowed in WAIT_LOCK before a retry.
- MAX_RETRIES, 3: DCM reset retries after the initial pulse before FAIL.

Ports:
- clk  input  1  27 MHz reference clock; the block's only clock.
- rst  input  1  asynchronous, active-high reset.
- ready  input  1  DCM lock indicator; asynchronous to clk.
- dcm_rst  output  1  active-high reset to the DCM.
- sys_rst  output  1  active-high reset to downstream logic.
- locked  output  1  high only in RUN.
- fail  output  1  sticky lock-failure flag.

Behaviour:
- Reset values (asynchronous on rst=1): state=DCM_RST, dcm_rst=1, sys_rst=1, locked=0, fail=0; all counters and the retry count = 0; both sync flops = 0.
- ready passes through a 2-flop synchronizer giving ready_s. ready_s reaches the FSM 2 edges after ready is first sampled high.
- All outputs are registered and decoded from state.
- Counter widths are $clog2(max+1). Counters never wrap; each is cleared on every state entry.
- DCM_RST:
  - dcm_rst=1, sys_rst=1.
  - After DCM_RST_CYCLES cycles in this state, go to WAIT_LOCK; dcm_rst falls on that same edge.
- WAIT_LOCK:
  - dcm_rst=0, sys_rst=1.
  - ready_s=1 -> STABLE, checked before timeout; ready_s=1 on the timeout edge wins.
  - Otherwise, at the LOCK_TIMEOUT_CYCLES-th cycle: if retry count == MAX_RETRIES -> FAIL; else increment retry count and go to DCM_RST.
- STABLE:
  - Counts consecutive cycles with ready_s=1.
  - ready_s=0 in any cycle -> WAIT_LOCK, with the timeout counter restarted.
  - When the count reaches LOCK_STABLE_CYCLES -> RUN.
- Release latency: if ready is first sampled high at edge N and stays high, sys_rst falls and locked rises at edge N+2+LOCK_STABLE_CYCLES.
- RUN:
  - sys_rst=0, locked=1.
  - ready_s=0 -> DCM_RST, retry count cleared. On that edge sys_rst rises and locked falls, i.e. 3 edges after ready drops.
- FAIL:
  - dcm_rst=0, sys_rst=1, locked=0, fail=1.
  - Absorbing state; exited only by rst. ready is ignored.
- rst asserted in any state, mid-count included: immediate return to reset values without waiting for a clock edge. Normal sequencing restarts on the first edge after rst falls.
- ready toggling faster than the sync depth must never produce locked=1 unless ready_s was 1 for LOCK_STABLE_CYCLES consecutive cycles.

Optional Feature:
- Macro: DCM_LOSS_CNT_EN.
- When defined, adds port loss_count (output, 8 bits):
  - Saturating count of RUN -> DCM_RST loss-of-lock transitions.
  - Reset to 0 only by rst; holds at 255.
- When undefined, the port and its counter do not exist; all other behaviour is identical.

Test Plan:
All scenarios use DCM_RST_CYCLES=3, LOCK_STABLE_CYCLES=8, LOCK_TIMEOUT_CYCLES=32, MAX_RETRIES=2.
- ready held 0 -> exactly 3 dcm_rst pulses, each 3 cycles wide and spaced 35 cycles apart; fail=1 at edge 105 after rst falls; sys_rst stays 1 throughout.
- ready rises 10 cycles after the first dcm_rst fall and stays high -> sys_rst falls and locked rises exactly 10 edges after ready is first sampled; dcm_rst stays 0.
- ready dropped for one cycle at the 5th STABLE cycle, then high -> locked held 0; release occurs 10 edges after ready is resampled high.
- ready dropped in RUN -> sys_rst=1 and locked=0 at edge 3 after the drop; one 3-cycle dcm_rst pulse follows; ready returned high -> normal release; retry count restarts from 0, so 2 further retries are allowed. With DCM_LOSS_CNT_EN, loss_count increments 0 -> 1.
- rst pulsed mid-RUN and mid-STABLE -> outputs return to reset values before the next clk edge; the full sequence repeats after rst falls.
- In FAIL, ready toggled for 100 cycles -> fail, sys_rst and locked unchanged; rst clears fail to 0.
